// File: rtl/rns_stream_convert.sv
// rns_stream_convert: streams signed coefficients through an external modular reducer into per-modulus residues; define RNS_ERROR_ADD_EN to add a sign-magnitude error term
module rns_stream_convert #(
    parameter int N           = 8192,
    parameter int LOGN        = 13,
    parameter int LOGQ        = 54,
    parameter int NUM_MOD     = 4,
    parameter int LOGM        = 2,
    parameter int IW          = 64,
    parameter int EW          = 6,
    parameter int BRAM_RD_LAT = 2,
    parameter int RED_LAT     = 13
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LOGM:0]           mod_count,
    input  logic [NUM_MOD*LOGQ-1:0] q_table,
    output logic                    busy,
    output logic                    done,
    output logic [LOGN-1:0]         in_rd_addr,
    input  logic [IW-1:0]           in_rd_data,
    output logic [LOGN-1:0]         err_rd_addr,
    input  logic [EW-1:0]           err_rd_data,
    output logic [IW-1:0]           red_in,
    output logic [LOGM-1:0]         red_sel,
    input  logic [LOGQ-1:0]         red_out,
    output logic [LOGN-1:0]         out_wr_addr,
    output logic [LOGM-1:0]         out_wr_sel,
    output logic [LOGQ-1:0]         out_wr_data,
    output logic                    out_wr_en
);
    localparam int P     = BRAM_RD_LAT + RED_LAT + 4;
    localparam int AGE_B = BRAM_RD_LAT + 1 + RED_LAT;
    localparam int AGE_D = P - 1;
    localparam logic [LOGM:0]   MC_MAX    = (LOGM + 1)'(NUM_MOD);
    localparam logic [LOGN-1:0] LAST_ADDR = LOGN'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nx;

    logic [LOGM:0]     mc;
    logic [LOGM-1:0]   sel;
    logic              last_issue;
    logic [P:1]        vld_p;
    logic [LOGN-1:0]   addr_p [1:P];
    logic [LOGM-1:0]   sel_p  [1:P];
    logic [RED_LAT:0]  sgn_p;
    logic [LOGQ-1:0]   q_b, q_d, m_nx, ev_nx, m_b, ev_b;
    logic [LOGQ:0]     s_c, s_sub;

    assign last_issue = state == RUN && in_rd_addr == LAST_ADDR && {1'b0, sel} == mc - 1'b1;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next state and status; done is the first DRAIN cycle with an empty pipeline
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        state_nx = state == IDLE ? (start ? RUN : IDLE) :
                   state == RUN  ? (last_issue ? DRAIN : RUN) :
                   (vld_p == '0 ? IDLE : DRAIN);
        busy     = state != IDLE;
        done     = state == DRAIN && vld_p == '0;
    end

    // read issue counters: coefficient index inner, modulus index outer, hold after last issue
    always_ff @(posedge clk) begin
        if (rst) begin
            in_rd_addr <= '0;
            sel        <= '0;
            mc         <= MC_MAX;
        end else if (state == IDLE && start) begin
            in_rd_addr <= '0;
            sel        <= '0;
            mc         <= (mod_count == '0 || mod_count > MC_MAX) ? MC_MAX : mod_count;
        end else if (state == RUN && !last_issue) begin
            in_rd_addr <= in_rd_addr == LAST_ADDR ? '0 : in_rd_addr + 1'b1;
            sel        <= in_rd_addr == LAST_ADDR ? sel + 1'b1 : sel;
        end
    end

    // index/valid delay line; element k holds what was issued k cycles ago
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
            for (int i = 1; i <= P; i++) begin
                addr_p[i] <= '0;
                sel_p[i]  <= '0;
            end
        end else begin
            vld_p     <= {vld_p[P-1:1], state == RUN};
            addr_p[1] <= in_rd_addr;
            sel_p[1]  <= sel;
            for (int i = 2; i <= P; i++) begin
                addr_p[i] <= addr_p[i-1];
                sel_p[i]  <= sel_p[i-1];
            end
        end
    end

    // stage A: magnitude to the reducer, sign carried alongside the reducer latency
    always_ff @(posedge clk) begin
        red_in <= in_rd_data[IW-1] ? -in_rd_data : in_rd_data;
        sgn_p  <= {sgn_p[RED_LAT-1:0], in_rd_data[IW-1]};
    end

    assign red_sel = sel_p[BRAM_RD_LAT+1];
    assign q_b     = q_table[sel_p[AGE_B]*LOGQ +: LOGQ];
    assign q_d     = q_table[sel_p[AGE_D]*LOGQ +: LOGQ];
    assign m_nx    = (sgn_p[RED_LAT] && red_out != '0) ? q_b - red_out : red_out;

`ifdef RNS_ERROR_ADD_EN
    logic [LOGQ-1:0] e_mag;
    assign e_mag       = LOGQ'(err_rd_data[EW-2:0]);
    assign ev_nx       = e_mag == '0 ? '0 : (err_rd_data[EW-1] ? q_b - e_mag : e_mag);
    assign err_rd_addr = addr_p[RED_LAT+1];
`else
    logic unused_err;
    assign unused_err  = ^err_rd_data;
    assign ev_nx       = '0;
    assign err_rd_addr = '0;
`endif

    assign s_sub = s_c - {1'b0, q_d};

    // stages B, C, D: sign fix-up and error map, wide add, conditional subtract
    always_ff @(posedge clk) begin
        m_b         <= m_nx;
        ev_b        <= ev_nx;
        s_c         <= {1'b0, m_b} + {1'b0, ev_b};
        out_wr_data <= s_c >= {1'b0, q_d} ? s_sub[LOGQ-1:0] : s_c[LOGQ-1:0];
    end

    assign out_wr_en   = vld_p[P];
    assign out_wr_addr = addr_p[P];
    assign out_wr_sel  = sel_p[P];
endmodule

// File: tb/tb_rns_stream_convert.sv
// tb_rns_stream_convert: randomized self-checking bench with BRAM and reducer models and an arithmetic residue model
module tb_rns_stream_convert;
    localparam int N = 8, LOGN = 3, LOGQ = 8, NUM_MOD = 2, LOGM = 1, IW = 16, EW = 6, BRL = 2, RL = 13;
    localparam int P = BRL + RL + 4;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [LOGM:0] mod_count = '0;
    logic [NUM_MOD*LOGQ-1:0] q_table = {8'd89, 8'd97};
    logic busy, done, out_wr_en;
    logic [LOGN-1:0] in_rd_addr, err_rd_addr, out_wr_addr;
    logic [IW-1:0] in_rd_data, red_in, cd1;
    logic [EW-1:0] err_rd_data, ed1;
    logic [LOGM-1:0] red_sel, out_wr_sel;
    logic [LOGQ-1:0] red_out, out_wr_data;
    logic [LOGQ-1:0] red_pipe [RL];
    logic [IW-1:0] coef [N];
    logic [EW-1:0] errm [N];
    int qv [NUM_MOD] = '{97, 89};

    int checks = 0, errors = 0, cyc = 0, start_cyc = 0;
    int wr_sel[$], wr_addr[$], wr_data[$], wr_cyc[$], done_cyc[$], addr_hist[$];
    int busy_first = 0, busy_last = 0, busy_cnt = 0, err_addr_bad = 0;

    rns_stream_convert #(.N(N), .LOGN(LOGN), .LOGQ(LOGQ), .NUM_MOD(NUM_MOD), .LOGM(LOGM), .IW(IW),
                         .EW(EW), .BRAM_RD_LAT(BRL), .RED_LAT(RL)) dut (
        .clk(clk), .rst(rst), .start(start), .mod_count(mod_count), .q_table(q_table),
        .busy(busy), .done(done), .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
        .err_rd_addr(err_rd_addr), .err_rd_data(err_rd_data), .red_in(red_in), .red_sel(red_sel),
        .red_out(red_out), .out_wr_addr(out_wr_addr), .out_wr_sel(out_wr_sel),
        .out_wr_data(out_wr_data), .out_wr_en(out_wr_en));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // two-cycle BRAMs and a RL-cycle reducer
    always @(posedge clk) begin
        cd1         <= coef[in_rd_addr];
        in_rd_data  <= cd1;
        ed1         <= errm[err_rd_addr];
        err_rd_data <= ed1;
        red_pipe[0] <= LOGQ'(int'(red_in) % qv[red_sel]);
        for (int i = 1; i < RL; i++) red_pipe[i] <= red_pipe[i-1];
    end
    assign red_out = red_pipe[RL-1];

    // capture writes, done pulses, busy span and error-address tracking
    always @(negedge clk) begin
        if (out_wr_en) begin
            wr_sel.push_back(int'(out_wr_sel));
            wr_addr.push_back(int'(out_wr_addr));
            wr_data.push_back(int'(out_wr_data));
            wr_cyc.push_back(cyc);
        end
        if (done) done_cyc.push_back(cyc);
        if (busy) begin
            if (busy_cnt == 0) busy_first = cyc;
            busy_last = cyc;
            busy_cnt++;
        end
        if (rst) addr_hist.delete();
        else begin
            addr_hist.push_front(int'(in_rd_addr));
            if (addr_hist.size() > RL + 2) void'(addr_hist.pop_back());
`ifdef RNS_ERROR_ADD_EN
            if (addr_hist.size() == RL + 2 && int'(err_rd_addr) != addr_hist[RL+1]) err_addr_bad++;
`else
            if (err_rd_addr != '0) err_addr_bad++;
`endif
        end
    end

    // residue of x + e modulo q_s, computed with plain signed arithmetic
    function automatic int ref_res(input int s, input int a);
        int q, x, r, e;
        q = qv[s];
        x = int'($signed(coef[a]));
        r = ((x % q) + q) % q;
`ifdef RNS_ERROR_ADD_EN
        e = errm[a][EW-1] ? -int'(errm[a][EW-2:0]) : int'(errm[a][EW-2:0]);
`else
        e = 0;
`endif
        return ((r + e) % q + q) % q;
    endfunction

    task automatic fill_random;
        for (int i = 0; i < N; i++) begin
            coef[i] = IW'($urandom);
            errm[i] = EW'($urandom);
        end
    endtask

    task automatic clear_cap;
        wr_sel.delete(); wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); done_cyc.delete();
        busy_cnt = 0; err_addr_bad = 0;
    endtask

    task automatic launch(input logic [LOGM:0] mc);
        @(posedge clk); #1;
        start = 1'b1; mod_count = mc; start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int n);
        for (int i = 0; i < 2000 && done_cyc.size() < n; i++) @(posedge clk);
        repeat (P + 4) @(posedge clk);
        #1;
        checks++;
        if (done_cyc.size() != n) begin
            errors++;
            $display("FAIL done_wait: got %0d done pulses expected %0d", done_cyc.size(), n);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
        checks++; if (out_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %0b expected 0", out_wr_en); end
        checks++; if (in_rd_addr !== '0) begin errors++; $display("FAIL reset_in_addr: got %0d expected 0", in_rd_addr); end
        checks++; if (err_rd_addr !== '0) begin errors++; $display("FAIL reset_err_addr: got %0d expected 0", err_rd_addr); end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({busy, done, out_wr_en} !== 3'b000) begin errors++; $display("FAIL idle_after_reset: got %b expected 000", {busy, done, out_wr_en}); end
    endtask

    task automatic test_directed;
        int exp0, exp1;
        fill_random();
        coef[0] = IW'(-5);   errm[0] = 6'h03;
        coef[1] = IW'(-97);  errm[1] = 6'h21;
        coef[2] = IW'(200);  errm[2] = 6'h00;
`ifdef RNS_ERROR_ADD_EN
        exp0 = 95; exp1 = 96;
`else
        exp0 = 92; exp1 = 0;
`endif
        clear_cap(); launch(2); wait_done(1);
        checks++;
        if (wr_data.size() != 2 * N) begin
            errors++; $display("FAIL directed_count: got %0d expected %0d", wr_data.size(), 2 * N);
        end else begin
            checks++; if (wr_data[0] != exp0) begin errors++; $display("FAIL neg5_plus3: got %0d expected %0d", wr_data[0], exp0); end
            checks++; if (wr_data[1] != exp1) begin errors++; $display("FAIL neg97_minus1: got %0d expected %0d", wr_data[1], exp1); end
            checks++; if (wr_data[N+2] != 22) begin errors++; $display("FAIL x200_q89: got %0d expected 22", wr_data[N+2]); end
        end
        checks++; if (err_addr_bad != 0) begin errors++; $display("FAIL err_addr_track: got %0d bad cycles expected 0", err_addr_bad); end
    endtask

    task automatic test_full_run;
        int last;
        fill_random();
        coef[0] = 16'h8000; coef[N-1] = 16'h7fff; errm[N-1] = 6'h20;
        clear_cap(); launch(0); wait_done(1);
        checks++; if (wr_data.size() != 2 * N) begin errors++; $display("FAIL full_count: got %0d expected %0d", wr_data.size(), 2 * N); end
        for (int i = 0; i < wr_data.size() && i < 2 * N; i++) begin
            checks++;
            if (wr_sel[i] != i / N || wr_addr[i] != i % N || wr_data[i] != ref_res(i / N, i % N)) begin
                errors++;
                $display("FAIL full_write%0d: got sel %0d addr %0d data %0d expected sel %0d addr %0d data %0d",
                         i, wr_sel[i], wr_addr[i], wr_data[i], i / N, i % N, ref_res(i / N, i % N));
            end
        end
        last = wr_cyc.size() > 0 ? wr_cyc[$] : -1;
        checks++; if (wr_cyc.size() == 0 || wr_cyc[0] != start_cyc + 1 + P) begin errors++; $display("FAIL latency: got first write cycle %0d expected %0d", wr_cyc.size() ? wr_cyc[0] : -1, start_cyc + 1 + P); end
        checks++; if (wr_cyc.size() == 0 || last - wr_cyc[0] != 2 * N - 1) begin errors++; $display("FAIL contiguous: got span %0d expected %0d", wr_cyc.size() ? last - wr_cyc[0] : -1, 2 * N - 1); end
        checks++; if (done_cyc.size() == 0 || done_cyc[0] != last + 1) begin errors++; $display("FAIL done_timing: got %0d expected %0d", done_cyc.size() ? done_cyc[0] : -1, last + 1); end
        checks++; if (busy_first != start_cyc + 1 || busy_last != last + 1 || busy_cnt != last + 1 - start_cyc) begin
            errors++; $display("FAIL busy_span: got %0d..%0d (%0d) expected %0d..%0d", busy_first, busy_last, busy_cnt, start_cyc + 1, last + 1);
        end
        checks++; if (err_addr_bad != 0) begin errors++; $display("FAIL err_addr_track: got %0d bad cycles expected 0", err_addr_bad); end
    endtask

    task automatic test_mod_count;
        fill_random();
        clear_cap(); launch(1); wait_done(1);
        checks++; if (wr_data.size() != N) begin errors++; $display("FAIL mc1_count: got %0d expected %0d", wr_data.size(), N); end
        for (int i = 0; i < wr_data.size() && i < N; i++) begin
            checks++;
            if (wr_sel[i] != 0 || wr_addr[i] != i || wr_data[i] != ref_res(0, i)) begin
                errors++; $display("FAIL mc1_write%0d: got sel %0d addr %0d data %0d expected sel 0 addr %0d data %0d", i, wr_sel[i], wr_addr[i], wr_data[i], i, ref_res(0, i));
            end
        end
        clear_cap(); launch(3); wait_done(1);
        checks++; if (wr_data.size() != 2 * N) begin errors++; $display("FAIL mc3_count: got %0d expected %0d", wr_data.size(), 2 * N); end
        for (int i = 0; i < wr_data.size() && i < 2 * N; i++) begin
            checks++;
            if (wr_sel[i] != i / N || wr_addr[i] != i % N || wr_data[i] != ref_res(i / N, i % N)) begin
                errors++; $display("FAIL mc3_write%0d: got sel %0d addr %0d data %0d expected data %0d", i, wr_sel[i], wr_addr[i], wr_data[i], ref_res(i / N, i % N));
            end
        end
    endtask

    task automatic test_back_to_back;
        int d1, s2;
        fill_random();
        clear_cap(); launch(0);
        repeat (4) @(posedge clk);
        #1; start = 1'b1; mod_count = 2'd1;
        @(posedge clk); #1; start = 1'b0; mod_count = 2'd0;
        for (int i = 0; i < 2000 && done_cyc.size() == 0; i++) begin @(negedge clk); #1; end
        start = 1'b1;
        d1 = done_cyc.size() ? done_cyc[0] : -1;
        @(posedge clk); #1;
        s2 = cyc;
        @(posedge clk); #1; start = 1'b0;
        wait_done(2);
        checks++; if (wr_data.size() != 4 * N) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", wr_data.size(), 4 * N); end
        checks++; if (s2 != d1 + 1) begin errors++; $display("FAIL b2b_start_cycle: got %0d expected %0d", s2, d1 + 1); end
        checks++; if (wr_cyc.size() <= 2 * N || wr_cyc[2*N] != s2 + 1 + P) begin errors++; $display("FAIL b2b_second_latency: got %0d expected %0d", wr_cyc.size() > 2 * N ? wr_cyc[2*N] : -1, s2 + 1 + P); end
        for (int i = 0; i < wr_data.size() && i < 4 * N; i++) begin
            checks++;
            if (wr_sel[i] != (i % (2 * N)) / N || wr_addr[i] != i % N || wr_data[i] != ref_res((i % (2 * N)) / N, i % N)) begin
                errors++; $display("FAIL b2b_write%0d: got sel %0d addr %0d data %0d expected data %0d", i, wr_sel[i], wr_addr[i], wr_data[i], ref_res((i % (2 * N)) / N, i % N));
            end
        end
    endtask

    task automatic test_reset_mid_run;
        fill_random();
        clear_cap(); launch(0);
        for (int i = 0; i < 2000 && wr_data.size() < 5; i++) begin @(negedge clk); #1; end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; busy_cnt = 0;
        repeat (40) @(posedge clk);
        #1;
        checks++; if (wr_data.size() != 5) begin errors++; $display("FAIL abort_writes: got %0d expected 5", wr_data.size()); end
        checks++; if (done_cyc.size() != 0) begin errors++; $display("FAIL abort_done: got %0d pulses expected 0", done_cyc.size()); end
        checks++; if (busy_cnt != 0) begin errors++; $display("FAIL abort_busy: got %0d busy cycles expected 0", busy_cnt); end
        fill_random();
        clear_cap(); launch(0); wait_done(1);
        checks++; if (wr_data.size() != 2 * N) begin errors++; $display("FAIL rerun_count: got %0d expected %0d", wr_data.size(), 2 * N); end
        for (int i = 0; i < wr_data.size() && i < 2 * N; i++) begin
            checks++;
            if (wr_sel[i] != i / N || wr_addr[i] != i % N || wr_data[i] != ref_res(i / N, i % N)) begin
                errors++; $display("FAIL rerun_write%0d: got sel %0d addr %0d data %0d expected data %0d", i, wr_sel[i], wr_addr[i], wr_data[i], ref_res(i / N, i % N));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin coef[i] = '0; errm[i] = '0; end
        test_reset();
        test_directed();
        test_full_run();
        test_mod_count();
        test_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no end of run expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/rns_stream_convert.md
RNS_STREAM_CONVERT -- requirements
Module: rns_stream_convert

Interface
REQ-001 SHALL have parameters: N 8192 coefficients per polynomial; LOGN 13 address width; LOGQ 54 residue width; NUM_MOD 4 moduli per run; LOGM 2 modulus-index width; IW 64 signed input width; EW 6 sign-magnitude error width; BRAM_RD_LAT 2 BRAM read latency; RED_LAT 13 external reducer latency.
REQ-002 SHALL have ports (name direction width meaning):
- clk in 1 clock
- rst in 1 synchronous active-high reset
- start in 1 one-cycle run request
- mod_count in LOGM+1 moduli to process, sampled on accepted start
- q_table in NUM_MOD*LOGQ moduli, q_i at bits [i*LOGQ +: LOGQ]
- busy out 1 run in progress
- done out 1 one-cycle completion pulse
- in_rd_addr out LOGN coefficient BRAM read address
- in_rd_data in IW signed two's-complement coefficient
- err_rd_addr out LOGN error BRAM read address
- err_rd_data in EW error, MSB sign, rest magnitude
- red_in out IW magnitude sent to reducer
- red_sel out LOGM modulus index sent to reducer
- red_out in LOGQ red_in mod q_sel, RED_LAT cycles after red_in
- out_wr_addr out LOGN coefficient index
- out_wr_sel out LOGM modulus index
- out_wr_data out LOGQ residue
- out_wr_en out 1 write strobe

Function
REQ-003 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE.
REQ-004 SHALL accept start only in IDLE; start in RUN/DRAIN ignored, no effect.
REQ-005 SHALL latch mod_count on accepted start; 0 or >NUM_MOD SHALL be treated as NUM_MOD.
REQ-006 In RUN SHALL issue one read per cycle, coefficient index 0..N-1 inner, modulus index 0..mod_count-1 outer; index N-1 wraps to 0 and increments modulus index.
REQ-007 SHALL leave RUN for DRAIN after issuing (N-1, mod_count-1); in_rd_addr holds thereafter.
REQ-008 Datapath per word: stage A registers |x| and sign (x<0) from in_rd_data; red_in=|x|, red_sel=modulus index; |-2^(IW-1)| SHALL be 2^(IW-1) unsigned.
REQ-009 Stage B registers m = (sign && red_out!=0) ? q-red_out : red_out, and error value ev = (mag==0) ? 0 : (esign ? q-mag : mag).
REQ-010 Stage C/D: two-cycle modular adder, s=m+ev; out = s>=q ? s-q : s, at LOGQ+1 bits internally.
REQ-011 err_rd_addr SHALL equal in_rd_addr delayed RED_LAT+1 cycles; error index is the coefficient index, reused across moduli.
REQ-012 Total latency in_rd_addr issue -> out_wr_en SHALL be P = BRAM_RD_LAT+RED_LAT+4 cycles, one write per cycle, no gaps.
REQ-013 out_wr_addr/out_wr_sel SHALL carry the index pair issued P cycles earlier.
REQ-014 DRAIN SHALL end after the final write; done SHALL pulse the cycle after final out_wr_en, FSM then IDLE.
REQ-015 busy SHALL be high from the cycle after accepted start through the done cycle inclusive.
REQ-016 start in the done cycle SHALL be ignored; start the following cycle accepted.
REQ-017 Inputs err mag >= q and red_out >= q are illegal; behaviour undefined.

Reset
REQ-018 On rst: FSM IDLE, busy 0, done 0, out_wr_en 0, in_rd_addr 0, err_rd_addr 0, all pipeline valid bits cleared.
REQ-019 rst mid-run SHALL abort; no out_wr_en from the aborted run after rst deasserts.

Configuration
REQ-020 With RNS_ERROR_ADD_EN defined: error read and addition per REQ-009..011.
REQ-021 Without RNS_ERROR_ADD_EN: ev forced 0, err_rd_addr held 0, err_rd_data ignored; latency P unchanged.

Verification (LOGQ=8, IW=16, EW=6, N=8, NUM_MOD=2, q_table={89,97}, bench reducer model, macro defined unless stated)
REQ-022 x=-5, e=+3, q0=97 -> residue 92+3 = 95 written at (addr k, sel 0).
REQ-023 x=-97, e=-1 (0x21), q=97 -> red_out 0, m=0, out 96; x=200, e=0, q1=89 -> 22.
REQ-024 start, mod_count=0 -> 16 writes, sel 0 then 1, addr 0..7 each, contiguous; done one cycle after 16th write; busy spans start+1..done.
REQ-025 start pulsed during RUN and in done cycle -> ignored; start next cycle -> new run of 16 writes.
REQ-026 rst asserted at write 5 -> no further out_wr_en, done 0, busy 0; next start yields full correct run.
REQ-027 Macro undefined, x=-5, e=+3, q=97 -> out 92, err_rd_addr constant 0.
